// File: rtl/esm_dispatch_buffer.sv
// esm_dispatch_buffer: instruction slot buffer between allocation, the IRT/IDT core and dispatch.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/Instr_in/ALUSrc/RegWrite/buffer_index
// allocate the lowest FREE slot; ready_valid/ready_index/ready_ack accept a slot from the core;
// disp_valid/disp_ready/disp_instr/disp_ALUSrc/disp_RegWrite/disp_index form the registered
// dispatch output; cmpl_valid/cmpl_index free an ISSUED slot; occupancy counts non-FREE slots;
// proto_err is a sticky protocol error. Defining ESM_DISPATCH_STATS_EN adds the saturating
// counters stat_dispatched and stat_stall.
module esm_dispatch_buffer #(
  parameter int Instr_word_size = 32,
  parameter int bs = 16,
  localparam int IW = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic                       ALUSrc,
  input  logic                       RegWrite,
  output logic [IW-1:0]              buffer_index,
  input  logic                       ready_valid,
  input  logic [IW-1:0]              ready_index,
  output logic                       ready_ack,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [Instr_word_size-1:0] disp_instr,
  output logic                       disp_ALUSrc,
  output logic                       disp_RegWrite,
  output logic [IW-1:0]              disp_index,
  input  logic                       cmpl_valid,
  input  logic [IW-1:0]              cmpl_index,
  output logic [IW:0]                occupancy,
  output logic                       proto_err
`ifdef ESM_DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_dispatched,
  output logic [31:0]                stat_stall
`endif
);
  typedef enum logic [1:0] {FREE, WAIT, ISSUED} slot_e;
  localparam int EW = Instr_word_size + 2;
  slot_e st_q [bs];
  slot_e st_d [bs];
  logic [EW-1:0] ent_q [bs];
  logic [EW-1:0] disp_ent_q;
  logic [IW-1:0] disp_idx_q;
  logic disp_valid_q, err_q, err_d;
  logic [IW:0] occ_q, occ_d;
  logic alloc, rd_wait, cmpl_ok;
  // Slot states and output-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) st_q[i] <= FREE;
      disp_valid_q <= 1'b0;
      disp_ent_q <= '0;
      disp_idx_q <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < bs; i++) st_q[i] <= st_d[i];
      occ_q <= occ_d;
      err_q <= err_d;
      if (ready_ack) begin
        disp_valid_q <= 1'b1;
        disp_ent_q <= ent_q[ready_index];
        disp_idx_q <= ready_index;
      end else if (disp_ready) disp_valid_q <= 1'b0;
    end
  end
  // Payload storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) if (alloc) ent_q[buffer_index] <= {ALUSrc, RegWrite, Instr_in};
  // Allocation pick, handshakes and error detection
  always_comb begin
    in_ready = 1'b0;
    buffer_index = '0;
    for (int i = bs - 1; i >= 0; i--)
      if (st_q[i] == FREE) begin
        in_ready = 1'b1;
        buffer_index = IW'(i);
      end
    alloc = in_valid & in_ready;
    rd_wait = st_q[ready_index] == WAIT;
    ready_ack = ready_valid & rd_wait & (!disp_valid_q | disp_ready);
    cmpl_ok = cmpl_valid & (st_q[cmpl_index] == ISSUED);
    err_d = err_q | (ready_valid & !rd_wait) | (cmpl_valid & !cmpl_ok);
    occ_d = occ_q + (IW + 1)'(alloc) - (IW + 1)'(cmpl_ok);
  end
  // The three events always target distinct slots, so their updates never collide
  always_comb begin
    for (int i = 0; i < bs; i++) st_d[i] = st_q[i];
    if (alloc) st_d[buffer_index] = WAIT;
    if (ready_ack) st_d[ready_index] = ISSUED;
    if (cmpl_ok) st_d[cmpl_index] = FREE;
  end
  assign disp_valid = disp_valid_q;
  assign {disp_ALUSrc, disp_RegWrite, disp_instr} = disp_ent_q;
  assign disp_index = disp_idx_q;
  assign occupancy = occ_q;
  assign proto_err = err_q;
`ifdef ESM_DISPATCH_STATS_EN
  logic [31:0] sd_q, ss_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q <= '0;
      ss_q <= '0;
    end else begin
      if (disp_valid_q && disp_ready && !(&sd_q)) sd_q <= sd_q + 32'd1;
      if (in_valid && !in_ready && !(&ss_q)) ss_q <= ss_q + 32'd1;
    end
  end
  assign stat_dispatched = sd_q;
  assign stat_stall = ss_q;
`endif
endmodule

// File: tb/tb_esm_dispatch_buffer.sv
// tb_esm_dispatch_buffer: scoreboard bench for esm_dispatch_buffer with a slot-level reference model.
module tb_esm_dispatch_buffer;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, ALUSrc = 0, RegWrite = 0;
  logic [31:0] Instr_in = 0, disp_instr;
  logic [3:0] buffer_index, ready_index = 0, disp_index, cmpl_index = 0;
  logic ready_valid = 0, ready_ack, disp_valid, disp_ready = 0, disp_ALUSrc, disp_RegWrite;
  logic cmpl_valid = 0, proto_err;
  logic [4:0] occupancy;
  esm_dispatch_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Instr_in(Instr_in),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .buffer_index(buffer_index),
    .ready_valid(ready_valid), .ready_index(ready_index), .ready_ack(ready_ack),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr),
    .disp_ALUSrc(disp_ALUSrc), .disp_RegWrite(disp_RegWrite), .disp_index(disp_index),
    .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index), .occupancy(occupancy), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] idx; logic [31:0] w; logic a; logic r;} exp_t;
  exp_t sb[$];
  int m_st[16];
  logic [33:0] m_w[16];
  bit m_dv, m_err;
  int n_chk = 0, n_err = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int lowfree();
    for (int i = 0; i < 16; i++) if (m_st[i] == 0) return i;
    return -1;
  endfunction
  function automatic int occ();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_st[i] != 0) n++;
    return n;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_st[i] = 0;
    m_dv = 0;
    m_err = 0;
    sb.delete();
  endtask
  // One clock: compare outputs at negedge, then advance the model with the sampled inputs
  task automatic step();
    int lf;
    bit ack, cok, al;
    @(negedge clk);
    lf = lowfree();
    ack = ready_valid && m_st[ready_index] == 1 && (!m_dv || disp_ready);
    cok = cmpl_valid && m_st[cmpl_index] == 2;
    al = in_valid && lf >= 0;
    chk("in_ready", in_ready, lf >= 0);
    chk("buffer_index", buffer_index, lf < 0 ? 0 : lf);
    chk("ready_ack", ready_ack, ack);
    chk("occupancy", occupancy, occ());
    chk("proto_err", proto_err, m_err);
    chk("disp_valid", disp_valid, m_dv);
    if (m_dv && sb.size() > 0) begin
      chk("disp_index", disp_index, sb[0].idx);
      chk("disp_instr", disp_instr, sb[0].w);
      chk("disp_ALUSrc", disp_ALUSrc, sb[0].a);
      chk("disp_RegWrite", disp_RegWrite, sb[0].r);
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (ready_valid && m_st[ready_index] != 1) m_err = 1;
      if (cmpl_valid && !cok) m_err = 1;
      if (m_dv && disp_ready) begin
        void'(sb.pop_front());
        m_dv = 0;
      end
      if (ack) begin
        sb.push_back(exp_t'({ready_index, m_w[ready_index][31:0], m_w[ready_index][33], m_w[ready_index][32]}));
        m_dv = 1;
        m_st[ready_index] = 2;
      end
      if (cok) m_st[cmpl_index] = 0;
      if (al) begin
        m_st[lf] = 1;
        m_w[lf] = {ALUSrc, RegWrite, Instr_in};
      end
    end
    #1;
  endtask
  task automatic put(input int k);
    in_valid = 1;
    Instr_in = 32'hA000_0000 + k;
    ALUSrc = k[0];
    RegWrite = ~k[1];
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_disp_instr", disp_instr, 0);
    chk("rst_disp_index", disp_index, 0);
    for (int k = 0; k < 3; k++) begin
      put(k);
      step();
    end
    in_valid = 0;
    chk("t1_occ", occupancy, 3);
    chk("t1_in_ready", in_ready, 1);
    ready_valid = 1;
    ready_index = 1;
    disp_ready = 1;
    #1 chk("t2_ack", ready_ack, 1);
    step();
    ready_valid = 0;
    chk("t2_dv", disp_valid, 1);
    chk("t2_idx", disp_index, 1);
    chk("t2_instr", disp_instr, 32'hA000_0001);
    disp_ready = 0;
    ready_valid = 1;
    ready_index = 2;
    repeat (4) step();
    chk("t3_hold_idx", disp_index, 1);
    disp_ready = 1;
    step();
    ready_valid = 0;
    chk("t3_idx", disp_index, 2);
    for (int k = 3; k < 16; k++) begin
      put(k);
      step();
    end
    chk("t4_full_ready", in_ready, 0);
    chk("t4_full_occ", occupancy, 16);
    put(99);
    step();
    in_valid = 0;
    ready_valid = 1;
    ready_index = 5;
    step();
    ready_valid = 0;
    cmpl_valid = 1;
    cmpl_index = 5;
    step();
    cmpl_valid = 0;
    chk("t4_in_ready", in_ready, 1);
    chk("t4_bidx", buffer_index, 5);
    chk("t4_occ", occupancy, 15);
    cmpl_valid = 1;
    cmpl_index = 7;
    step();
    cmpl_valid = 0;
    chk("t5_err", proto_err, 1);
    chk("t5_occ", occupancy, 15);
    ready_valid = 1;
    ready_index = 5;
    step();
    ready_valid = 0;
    chk("t5_err_sticky", proto_err, 1);
    put(50);
    ready_valid = 1;
    ready_index = 3;
    cmpl_valid = 1;
    cmpl_index = 1;
    step();
    {in_valid, ready_valid, cmpl_valid} = 0;
    chk("t6_occ", occupancy, 15);
    for (int n = 0; n < 300; n++) begin
      in_valid = $urandom_range(0, 1);
      Instr_in = $urandom;
      ALUSrc = $urandom_range(0, 1);
      RegWrite = $urandom_range(0, 1);
      ready_valid = $urandom_range(0, 2) != 0;
      ready_index = 4'($urandom_range(0, 15));
      disp_ready = $urandom_range(0, 3) != 0;
      cmpl_valid = $urandom_range(0, 2) == 0;
      cmpl_index = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1;
    disp_ready = 0;
    step();
    {rst, in_valid, ready_valid, cmpl_valid} = 0;
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_dv", disp_valid, 0);
    chk("t6_rst_err", proto_err, 0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
